// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every DIV clocks; Compare match raises timer_int.
// Optional: define CP0_TIMER_IRQ_EN to build the pending flag and match comparator.
module cp0_timer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DIV          = 2,
    parameter logic [5:0]  COUNT_ADDR   = 6'd9,
    parameter logic [5:0]  COMPARE_ADDR = 6'd11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mtc0_we,
    input  logic             exception,
    input  logic [5:0]       cp0_addr,
    input  logic [WIDTH-1:0] mtc0_data,
    input  logic             count_freeze,
    output logic [WIDTH-1:0] cp0_Count_data,
    output logic [WIDTH-1:0] cp0_Compare_data,
    output logic             timer_int
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]    div_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] compare_q;
    logic             wr;
    logic             count_wr;
    logic             compare_wr;
    logic             tick;

    assign wr         = mtc0_we & ~exception;
    assign count_wr   = wr & (cp0_addr == COUNT_ADDR);
    assign compare_wr = wr & (cp0_addr == COMPARE_ADDR);
    assign tick       = ~count_freeze & (div_q == DIV_LAST);

    // Divider: a Count write restarts the prescale period so the next tick is DIV clocks away
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (count_wr) begin
            div_q <= '0;
        end else if (!count_freeze) begin
            div_q <= (div_q == DIV_LAST) ? '0 : DW'(div_q + DW'(1));
        end
    end

    // Count: the write wins over a same-cycle tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (count_wr) begin
            count_q <= mtc0_data;
        end else if (tick) begin
            count_q <= WIDTH'(count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q <= '0;
        end else if (compare_wr) begin
            compare_q <= mtc0_data;
        end
    end

`ifdef CP0_TIMER_IRQ_EN
    logic pending_q;
    logic match;

    // Looking one count ahead lets the flag rise on the same edge Count lands on Compare
    assign match = tick & ~count_wr & (WIDTH'(count_q + WIDTH'(1)) == compare_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (compare_wr) begin
            pending_q <= 1'b0;
        end else if (match) begin
            pending_q <= 1'b1;
        end
    end

    assign timer_int = pending_q;
`else
    assign timer_int = 1'b0;
`endif

    assign cp0_Count_data   = count_q;
    assign cp0_Compare_data = compare_q;

endmodule

// File: tb/tb_cp0_timer.sv
// Scoreboard bench for cp0_timer (WIDTH=32, DIV=2); expectations follow CP0_TIMER_IRQ_EN.
module tb_cp0_timer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DIV   = 2;
    localparam logic [5:0]  A_CNT = 6'd9;
    localparam logic [5:0]  A_CMP = 6'd11;
`ifdef CP0_TIMER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mtc0_we = 1'b0;
    logic             exception = 1'b0;
    logic [5:0]       cp0_addr = '0;
    logic [WIDTH-1:0] mtc0_data = '0;
    logic             count_freeze = 1'b0;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cmp;
    logic             irq;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] compare;
        logic             irq;
    } exp_t;

    exp_t q[$];

    int unsigned      n_chk = 0;
    int unsigned      n_bad = 0;
    logic [WIDTH-1:0] m_count = '0;
    logic [WIDTH-1:0] m_cmp = '0;
    int unsigned      m_div = 0;
    logic             m_pend = 1'b0;

    cp0_timer #(
        .WIDTH(WIDTH), .DIV(DIV), .COUNT_ADDR(A_CNT), .COMPARE_ADDR(A_CMP)
    ) u_dut (
        .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .exception(exception),
        .cp0_addr(cp0_addr), .mtc0_data(mtc0_data), .count_freeze(count_freeze),
        .cp0_Count_data(cnt), .cp0_Compare_data(cmp), .timer_int(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic exc, input logic [5:0] addr,
                         input logic [WIDTH-1:0] data, input logic frz);
        mtc0_we = we; exception = exc; cp0_addr = addr; mtc0_data = data; count_freeze = frz;
    endtask

    task automatic idle(input logic frz);
        drive(1'b0, 1'b0, 6'd0, '0, frz);
    endtask

    // Predict the next-edge state from the architectural rules, queue it, then check after the edge
    task automatic step();
        logic       wr, cw, mw, tk, match;
        logic [WIDTH-1:0] inc;
        exp_t e;
        wr    = mtc0_we & ~exception;
        cw    = wr && (cp0_addr == A_CNT);
        mw    = wr && (cp0_addr == A_CMP);
        tk    = !count_freeze && (m_div == DIV - 1);
        inc   = m_count + 32'd1;
        match = tk && !cw && (inc == m_cmp);
        if (cw)                 m_div = 0;
        else if (!count_freeze) m_div = (m_div == DIV - 1) ? 0 : m_div + 1;
        if (cw)      m_count = mtc0_data;
        else if (tk) m_count = inc;
        if (mw) m_cmp = mtc0_data;
        if (!IRQ_EN)    m_pend = 1'b0;
        else if (mw)    m_pend = 1'b0;
        else if (match) m_pend = 1'b1;
        e.count = m_count; e.compare = m_cmp; e.irq = m_pend;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("count", cnt, e.count);
        chk("compare", cmp, e.compare);
        chk("irq", WIDTH'(irq), WIDTH'(e.irq));
    endtask

    task automatic model_reset();
        m_count = '0; m_cmp = '0; m_div = 0; m_pend = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_count", cnt, '0);
        chk("rst_compare", cmp, '0);
        chk("rst_irq", WIDTH'(irq), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Ten idle clocks at DIV=2 give five increments
        idle(1'b0);
        repeat (10) step();
        chk("count_after10", cnt, 32'd5);

        // Count=0x1E, Compare=0x20, then run through the match
        drive(1'b1, 1'b0, A_CNT, 32'h1E, 1'b0); step();
        drive(1'b1, 1'b0, A_CMP, 32'h20, 1'b0); step();
        idle(1'b0);
        repeat (3) step();
        chk("match_count", cnt, 32'h20);
        chk("match_irq", WIDTH'(irq), WIDTH'(IRQ_EN));
        repeat (4) step();
        chk("irq_sticky", WIDTH'(irq), WIDTH'(IRQ_EN));
        drive(1'b1, 1'b0, A_CMP, 32'h100, 1'b0); step();
        chk("irq_cleared", WIDTH'(irq), '0);

        // Compare write on the match edge wins
        drive(1'b1, 1'b0, A_CNT, 32'h1F, 1'b0); step();
        drive(1'b1, 1'b0, A_CMP, 32'h20, 1'b0); step();
        drive(1'b1, 1'b0, A_CMP, 32'h40, 1'b0); step();
        chk("coincident_count", cnt, 32'h20);
        chk("coincident_cmp", cmp, 32'h40);
        chk("coincident_irq", WIDTH'(irq), '0);

        // Count wraps from all-ones and matches Compare=0
        drive(1'b1, 1'b0, A_CMP, 32'h0, 1'b0); step();
        drive(1'b1, 1'b0, A_CNT, 32'hFFFF_FFFF, 1'b0); step();
        idle(1'b0);
        repeat (2) step();
        chk("wrap_count", cnt, 32'h0);
        chk("wrap_irq", WIDTH'(irq), WIDTH'(IRQ_EN));
        drive(1'b1, 1'b0, A_CMP, 32'h5, 1'b0); step();
        drive(1'b1, 1'b0, A_CNT, 32'h5, 1'b0); step();
        idle(1'b0);
        repeat (4) step();
        chk("cntwr_no_irq", WIDTH'(irq), '0);

        // Cancelled and off-address writes are ignored
        drive(1'b1, 1'b1, A_CMP, 32'h55, 1'b0); step();
        chk("exc_cmp", cmp, 32'h5);
        drive(1'b1, 1'b0, 6'd12, 32'h77, 1'b0); step();
        drive(1'b1, 1'b1, A_CNT, 32'h99, 1'b0); step();

        // Freeze holds Count but writes still land
        idle(1'b1);
        repeat (8) step();
        drive(1'b1, 1'b0, A_CMP, 32'h1234, 1'b1); step();
        drive(1'b1, 1'b0, A_CNT, 32'h1230, 1'b1); step();
        idle(1'b0);
        repeat (10) step();

        // Random traffic with Compare placed just ahead of Count to provoke matches
        for (int i = 0; i < 300; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       drive(1'b1, 1'($urandom_range(0, 1)), A_CNT, $urandom, 1'b0);
                1, 2:    drive(1'b1, 1'($urandom_range(0, 3) == 0), A_CMP,
                               m_count + 32'($urandom_range(1, 6)), 1'b0);
                3:       drive(1'b1, 1'b0, 6'($urandom_range(0, 63)), $urandom, 1'b0);
                4:       idle(1'b1);
                default: idle(1'b0);
            endcase
            step();
        end

        // Async reset mid-cycle with a pending interrupt
        drive(1'b1, 1'b0, A_CMP, 32'h3000, 1'b0); step();
        drive(1'b1, 1'b0, A_CNT, 32'h2FFF, 1'b0); step();
        idle(1'b0);
        repeat (2) step();
        chk("pre_rst_irq", WIDTH'(irq), WIDTH'(IRQ_EN));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", cnt, '0);
        chk("async_rst_cmp", cmp, '0);
        chk("async_rst_irq", WIDTH'(irq), '0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) step();
        chk("post_rst_count", cnt, 32'd3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_timer.md
CP0_TIMER -- requirements
Module: cp0_timer

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the Count and Compare registers (legal range 8..32).
REQ-002 Parameter DIV, default 2, number of clk cycles per Count increment (legal range 1..16).
REQ-003 Parameter COUNT_ADDR, default 6'd9, cp0_addr value that selects Count.
REQ-004 Parameter COMPARE_ADDR, default 6'd11, cp0_addr value that selects Compare.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-high.
REQ-007 mtc0_we  input  1  MTC0 write strobe for the current cycle.
REQ-008 exception  input  1  the MTC0 instruction is cancelled by an exception; it suppresses the write.
REQ-009 cp0_addr  input  6  CP0 register address of the write.
REQ-010 mtc0_data  input  WIDTH  write data.
REQ-011 count_freeze  input  1  debug halt; it freezes the divider and Count.
REQ-012 cp0_Count_data  output  WIDTH  current Count value.
REQ-013 cp0_Compare_data  output  WIDTH  current Compare value.
REQ-014 timer_int  output  1  timer interrupt pending (to Cause.IP7).

Function
REQ-015 The block SHALL compute the effective write as wr = mtc0_we & ~exception; a write with exception=1 SHALL have no effect on any state.
REQ-016 The divider SHALL count 0..DIV-1 while count_freeze=0 and wrap to 0; tick SHALL be asserted in the cycle the divider equals DIV-1 (every cycle when DIV=1).
REQ-017 On tick, Count SHALL increment by 1 modulo 2^WIDTH, so 2^WIDTH-1 wraps to 0.
REQ-018 While count_freeze=1, the divider and Count SHALL hold, and MTC0 writes SHALL still take effect.
REQ-019 A write with cp0_addr==COUNT_ADDR SHALL load Count with mtc0_data and clear the divider at the same edge; a tick in that cycle SHALL be discarded (the write wins).
REQ-020 A write with cp0_addr==COMPARE_ADDR SHALL load Compare with mtc0_data at the next edge.
REQ-021 The match event SHALL be tick & (Count+1 == Compare), compared at WIDTH bits; it SHALL set the pending flag at the same edge that Count reaches Compare.
REQ-022 A Count write SHALL never generate a match, even when the loaded value equals Compare.
REQ-023 A Compare write SHALL clear the pending flag; if a Compare write and a match occur in the same cycle, the flag SHALL be cleared (the write wins).
REQ-024 The pending flag SHALL otherwise stay set until a Compare write or reset; further matches while it is set SHALL have no further effect.
REQ-025 The outputs SHALL be direct register outputs with zero cycles of combinational path from the inputs; readback SHALL show the new value in the cycle after the write edge.
REQ-026 Writes to any other address SHALL be ignored.

Reset
REQ-027 While rst=1, Count, Compare, the divider and the pending flag SHALL be 0 asynchronously, so cp0_Count_data=0, cp0_Compare_data=0 and timer_int=0.
REQ-028 After rst is deasserted, the first tick SHALL occur DIV rising edges later.
REQ-029 A reset asserted mid-count or with the flag pending SHALL clear all state immediately, with no residual interrupt.

Configuration
REQ-030 Macro CP0_TIMER_IRQ_EN defined: the pending flag and timer_int behave per REQ-021..REQ-024.
REQ-031 Macro CP0_TIMER_IRQ_EN undefined: there SHALL be no pending flag or match comparator, timer_int SHALL be constant 0, and Count/Compare behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then 10 cycles with DIV=2 -> cp0_Count_data=5, timer_int=0.
REQ-033 Write Compare=0x20 with Count=0x1E -> timer_int rises at the same edge Count becomes 0x20; a later Compare write clears it one edge after the write.
REQ-034 Compare write coincident with the match edge (Count 0x1F->0x20, writing Compare=0x40) -> timer_int stays 0 and Compare=0x40.
REQ-035 Count write 0xFFFFFFFF with DIV=1, WIDTH=32 -> next edge Count=0; with Compare=0, timer_int=1; writing Count=Compare directly -> timer_int stays 0.
REQ-036 mtc0_we=1, exception=1, addr=COMPARE_ADDR, data=0x55 -> Compare unchanged; count_freeze=1 for 8 cycles -> Count unchanged.
REQ-037 Assert rst asynchronously mid-cycle with timer_int=1 -> all outputs 0 before the next clk edge; rebuild without CP0_TIMER_IRQ_EN -> timer_int is 0 throughout REQ-033.
